// File: rtl/axis_adc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_adc_pkg
// Purpose  : Shared types, widths and helpers for the ADC decimator.
// Revision : 1.0 - initial release
// ============================================================================
package axis_adc_pkg;

    localparam int DATA_WIDTH_DEF     = 32;
    localparam int MAX_LOG2_RATIO_DEF = 8;
    localparam int ACC_WIDTH          = DATA_WIDTH_DEF + MAX_LOG2_RATIO_DEF;
    localparam int EXT_WIDTH          = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Replicates bit (width-1) into every higher bit of a wide container.
    function automatic logic [EXT_WIDTH-1:0] sign_ext(input logic [EXT_WIDTH-1:0] value,
                                                      input int width);
        logic [EXT_WIDTH-1:0] r;
        r = value;
        for (int i = 0; i < EXT_WIDTH; i++) begin
            if (i >= width) r[i] = value[width-1];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_adc_decimator_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : axis_out_reg
// Purpose  : Single-entry AXI-Stream output register carrying data and last.
// Revision : 1.0 - initial release
// ============================================================================
module axis_out_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
);

    // A new word may enter in the same cycle the held word leaves.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_data  <= in_data;
            out_last  <= in_last;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_adc_decimator.sv
`default_nettype none
// ============================================================================
// Module   : axis_adc_decimator
// Purpose  : Averages 2^k signed ADC samples per output and frames packets.
// Revision : 1.0 - initial release
// ============================================================================
module axis_adc_decimator
    import axis_adc_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int MAX_LOG2_RATIO = MAX_LOG2_RATIO_DEF,
    parameter int PACKET_LEN     = 256
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic                                  enable,
    input  logic [$clog2(MAX_LOG2_RATIO+1)-1:0]   log2_ratio,
    input  logic [DATA_WIDTH-1:0]                 s_axis_tdata,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    output logic [DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast,
    output logic                                  overrun
);

    localparam int RW = $clog2(MAX_LOG2_RATIO + 1);
    localparam int AW = DATA_WIDTH + MAX_LOG2_RATIO;
    localparam int CW = MAX_LOG2_RATIO;
    localparam int PW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
    localparam logic [RW-1:0] MAX_K    = RW'(MAX_LOG2_RATIO);
    localparam logic [PW-1:0] LAST_IDX = PW'(PACKET_LEN - 1);

    state_t          state, state_next;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   ratio_q;
    logic [PW-1:0]   pkt_cnt;
    logic            overrun_q;

    logic [RW-1:0]   ratio_clamped;
    logic [CW:0]     block_mask;
    logic            block_last;
    logic [AW-1:0]   sample_ext;
    logic [AW-1:0]   sum;
    logic [DATA_WIDTH-1:0] result;
    logic            run;
    logic            out_can_load;
    logic            s_hs;
    logic            complete;
    logic            m_hs;
    logic [PW-1:0]   pkt_next;
    logic            load_last;

    assign ratio_clamped = (log2_ratio > MAX_K) ? MAX_K : log2_ratio;
    assign block_mask    = ((CW+1)'(1) << ratio_q) - (CW+1)'(1);
    assign block_last    = ({1'b0, cnt} == block_mask);
    assign sample_ext    = AW'(sign_ext(EXT_WIDTH'(s_axis_tdata), DATA_WIDTH));
    assign sum           = acc + sample_ext;
    assign result        = DATA_WIDTH'($signed(sum) >>> ratio_q);

    assign run           = (state == RUN) && enable;
    assign s_axis_tready = run && (!block_last || out_can_load);
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign complete      = s_hs && block_last;
    assign m_hs          = m_axis_tvalid && m_axis_tready;
    assign pkt_next      = (pkt_cnt == LAST_IDX) ? '0 : pkt_cnt + PW'(1);
    // If the held word drains this cycle, the new word is the next in the packet.
    assign load_last     = ((m_hs ? pkt_next : pkt_cnt) == LAST_IDX);
    assign overrun       = overrun_q;

    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = ARM;
            ARM:     state_next = enable ? RUN : IDLE;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            acc       <= '0;
            cnt       <= '0;
            ratio_q   <= '0;
            pkt_cnt   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (!run) begin
                acc <= '0;
                cnt <= '0;
            end else if (s_hs) begin
                if (block_last) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CW'(1);
                end
            end

            if (state == ARM || complete) ratio_q <= ratio_clamped;

            if (state == IDLE)  pkt_cnt <= '0;
            else if (m_hs)      pkt_cnt <= pkt_next;

            // The ADC cannot be stalled, so a refused sample is lost data.
            if (run && s_axis_tvalid && !s_axis_tready) overrun_q <= 1'b1;
        end
    end

    axis_out_reg #(
        .WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk       (aclk),
        .rst       (areset),
        .in_data   (result),
        .in_last   (load_last),
        .in_valid  (complete),
        .in_ready  (out_can_load),
        .out_data  (m_axis_tdata),
        .out_last  (m_axis_tlast),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

endmodule
`default_nettype wire
